// File: rtl/seq_counter_prog.sv
// seq_counter_prog: programmable arbitrary-sequence counter.
//
// The count steps through a runtime-writable table of WIDTH-bit codes. Sequence length,
// direction and wrap/one-shot behaviour are selected at runtime.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset (also reloads the identity table)
//   en_i       step enable, one step per cycle
//   dir_i      1 = forward (idx+1), 0 = backward (idx-1)
//   oneshot_i  1 = stop at the end of the sequence, 0 = wrap
//   start_i    restart pulse: reload start index, clear done
//   seq_len_i  active sequence length; 0 or >DEPTH selects DEPTH
//   wr_en_i    table write strobe
//   wr_addr_i  table write address
//   wr_data_i  table write data
//   count_o    current sequence code (registered)
//   idx_o      current table index (registered)
//   tc_o       index is at the end for the current direction (combinational)
//   done_o     one-shot finished, sticky until start/reset
//   par_err_o  sticky table parity error
//
// Optional build macro SEQCNT_PARITY_EN: adds an even-parity bit per table entry that is
// checked on every count load. Without it par_err_o is tied to 0.
module seq_counter_prog #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned LEN_W = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             oneshot_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] seq_len_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] count_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             tc_o,
  output logic             done_o,
  output logic             par_err_o
);

  // Reset contents of entry i: the index itself, truncated to WIDTH.
  function automatic logic [WIDTH-1:0] init_code(input int unsigned i);
    return WIDTH'(i);
  endfunction

  logic [WIDTH-1:0] table_q [DEPTH];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_m1;
  logic [IDX_W-1:0] last_idx;
  logic             in_range;
  logic             at_end;
  logic             fwd_hit;

  // Effective length: out-of-range programming falls back to the full table.
  always_comb begin
    len = seq_len_i;
    if (seq_len_i == '0 || seq_len_i > LEN_W'(DEPTH)) begin
      len = LEN_W'(DEPTH);
    end
  end

  assign len_m1   = len - LEN_W'(1);
  assign last_idx = len_m1[IDX_W-1:0];
  assign in_range = {1'b0, idx_q} < len;
  assign at_end   = dir_i ? (idx_q == last_idx) : (idx_q == '0);
  assign tc_o     = at_end;

  always_comb begin
    idx_d  = idx_q;
    done_d = done_q;
    if (start_i) begin
      idx_d  = dir_i ? '0 : last_idx;
      done_d = 1'b0;
    end else if (en_i && !done_q) begin
      if (oneshot_i && at_end && in_range) begin
        done_d = 1'b1;
      end else if (dir_i) begin
        idx_d = (at_end || !in_range) ? '0 : idx_q + IDX_W'(1);
      end else begin
        // Backward: wrap from 0, or re-enter at the top when the length shrank below idx.
        idx_d = (at_end || !in_range) ? last_idx : idx_q - IDX_W'(1);
      end
    end
  end

  // A write to the entry being loaded this cycle is forwarded straight into count.
  assign fwd_hit = wr_en_i && (wr_addr_i == idx_d);

  always_comb begin
    count_d = table_q[idx_d];
    if (fwd_hit) begin
      count_d = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= init_code(i);
      end
    end else if (wr_en_i) begin
      table_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign idx_o   = idx_q;
  assign done_o  = done_q;

`ifdef SEQCNT_PARITY_EN
  logic par_q [DEPTH];
  logic par_err_q, par_err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= ^init_code(i);
      end
    end else if (wr_en_i) begin
      par_q[wr_addr_i] <= ^wr_data_i;
    end
  end

  // Forwarded data never passed through storage, so only table reads are checked.
  always_comb begin
    par_err_d = par_err_q;
    if (!fwd_hit && ((^table_q[idx_d]) != par_q[idx_d])) begin
      par_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err_o = par_err_q;
`else
  assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_seq_counter_prog.sv
// Testbench for seq_counter_prog. Stimulus pushes the expected post-edge state into a
// queue; an independent monitor pops and compares after every clock edge or reset assertion.
module tb_seq_counter_prog;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, dir, oneshot, start;
  logic [LEN_W-1:0] seq_len;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] count;
  logic [IDX_W-1:0] idx;
  logic             tc, done, par_err;

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic [IDX_W-1:0] i;
    logic             t;
    logic             d;
    logic             p;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic [WIDTH-1:0] tbl [11];

  seq_counter_prog #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .IDX_W(IDX_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .dir_i     (dir),
    .oneshot_i (oneshot),
    .start_i   (start),
    .seq_len_i (seq_len),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .count_o   (count),
    .idx_o     (idx),
    .tc_o      (tc),
    .done_o    (done),
    .par_err_o (par_err)
  );

  always #5 clk = ~clk;

  task automatic expect_state(input logic [WIDTH-1:0] c, input logic [IDX_W-1:0] i,
                              input logic t, input logic d, input logic p, input string nm);
    exp_t e;
    e.c = c;
    e.i = i;
    e.t = t;
    e.d = d;
    e.p = p;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Expect a state after the next rising edge; returns well clear of the edge.
  task automatic step(input logic [WIDTH-1:0] c, input logic [IDX_W-1:0] i,
                      input logic t, input logic d, input logic p, input string nm);
    expect_state(c, i, t, d, p, nm);
    @(posedge clk);
    #2;
  endtask

  // Monitor
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if ({count, idx, tc, done, par_err} !== e) begin
          n_err++;
          $display("FAIL %s: got count=%h idx=%0d tc=%b done=%b par_err=%b, expected count=%h idx=%0d tc=%b done=%b par_err=%b",
                   nm, count, idx, tc, done, par_err, e.c, e.i, e.t, e.d, e.p);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b1;
    en      = 1'b0;
    dir     = 1'b1;
    oneshot = 1'b0;
    start   = 1'b0;
    seq_len = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    tbl = '{8'h02, 8'h01, 8'h04, 8'h08, 8'h00, 8'h10, 8'h11, 8'h20, 8'h40, 8'h41, 8'h80};

    #1;
    expect_state(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "reset_async");
    rst_n = 1'b0;
    #2;
    en = 1'b1;
    step(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "reset_hold_en");
    rst_n = 1'b1;

    // Identity table, full length, forward wrap.
    for (int k = 1; k < 16; k++) step(8'(k), 4'(k), k == 15, 1'b0, 1'b0, "ident_fwd");
    step(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "ident_wrap");

    // Program the table while parked at idx 0; the write to entry 0 is forwarded.
    en    = 1'b0;
    wr_en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      wr_addr = 4'(k);
      wr_data = tbl[k];
      step(8'h02, 4'd0, 1'b0, 1'b0, 1'b0, "table_write");
    end
    wr_en = 1'b0;

    seq_len = 5'd11;
    start   = 1'b1;
    step(8'h02, 4'd0, 1'b0, 1'b0, 1'b0, "start_fwd_en0");
    start = 1'b0;
    en    = 1'b1;
    for (int k = 1; k < 11; k++) step(tbl[k], 4'(k), k == 10, 1'b0, 1'b0, "seq_fwd");
    step(8'h02, 4'd0, 1'b0, 1'b0, 1'b0, "seq_fwd_wrap");

    dir   = 1'b0;
    start = 1'b1;
    step(8'h80, 4'd10, 1'b0, 1'b0, 1'b0, "start_bwd");
    start = 1'b0;
    for (int k = 9; k >= 0; k--) step(tbl[k], 4'(k), k == 0, 1'b0, 1'b0, "seq_bwd");
    step(8'h80, 4'd10, 1'b0, 1'b0, 1'b0, "seq_bwd_wrap");

    // One-shot over the first four entries.
    dir     = 1'b1;
    oneshot = 1'b1;
    seq_len = 5'd4;
    start   = 1'b1;
    step(8'h02, 4'd0, 1'b0, 1'b0, 1'b0, "os_start");
    start = 1'b0;
    for (int k = 1; k < 4; k++) step(tbl[k], 4'(k), k == 3, 1'b0, 1'b0, "os_step");
    step(8'h08, 4'd3, 1'b1, 1'b1, 1'b0, "os_done");
    step(8'h08, 4'd3, 1'b1, 1'b1, 1'b0, "os_hold");
    oneshot = 1'b0;
    step(8'h08, 4'd3, 1'b1, 1'b1, 1'b0, "done_sticky");
    start = 1'b1;
    step(8'h02, 4'd0, 1'b0, 1'b0, 1'b0, "os_restart");
    start = 1'b0;

    // Write/step collision on the entry being stepped onto.
    step(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, "pre_collide");
    wr_en   = 1'b1;
    wr_addr = 4'd2;
    wr_data = 8'hAA;
    step(8'hAA, 4'd2, 1'b0, 1'b0, 1'b0, "collide_fwd");
    wr_en = 1'b0;
    en    = 1'b0;
    step(8'hAA, 4'd2, 1'b0, 1'b0, 1'b0, "collide_stored");

    // Length 1: idx beyond length folds to 0, then stays there in both directions.
    seq_len = 5'd1;
    en      = 1'b1;
    step(8'h02, 4'd0, 1'b1, 1'b0, 1'b0, "len1_oob");
    step(8'h02, 4'd0, 1'b1, 1'b0, 1'b0, "len1_hold");
    dir = 1'b0;
    step(8'h02, 4'd0, 1'b1, 1'b0, 1'b0, "len1_bwd");

    // Reset mid-run at idx 6.
    dir     = 1'b1;
    seq_len = '0;
    step(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, "run_1");
    step(8'hAA, 4'd2, 1'b0, 1'b0, 1'b0, "run_2");
    step(8'h08, 4'd3, 1'b0, 1'b0, 1'b0, "run_3");
    step(8'h00, 4'd4, 1'b0, 1'b0, 1'b0, "run_4");
    step(8'h10, 4'd5, 1'b0, 1'b0, 1'b0, "run_5");
    step(8'h11, 4'd6, 1'b0, 1'b0, 1'b0, "run_6");
    expect_state(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "reset_mid");
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, "post_reset_1");
    step(8'h02, 4'd2, 1'b0, 1'b0, 1'b0, "post_reset_ident");

`ifdef SEQCNT_PARITY_EN
    // Corrupt entry 3 (0x03 -> 0x02) behind the parity bit's back.
    en = 1'b0;
    dut.table_q[3][0] = ~dut.table_q[3][0];
    en = 1'b1;
    step(8'h02, 4'd3, 1'b0, 1'b0, 1'b1, "par_detect");
    en = 1'b0;
    step(8'h02, 4'd3, 1'b0, 1'b0, 1'b1, "par_hold");
    en = 1'b1;
    step(8'h04, 4'd4, 1'b0, 1'b0, 1'b1, "par_sticky");
`endif

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_counter_prog.md
Name: seq_counter_prog

Overview:
Parametrised arbitrary-sequence counter. The count steps through a user-programmable table of WIDTH-bit codes rather than a fixed hard-coded sequence. Features:
- runtime-programmable table and sequence length
- up/down stepping
- wrap or one-shot mode, with terminal-count and done flags

It is the general-purpose replacement for the fixed-sequence counters in the ch6 exercise set. It drives display or test-pattern logic.

Parameters:
WIDTH, 8, bit width of each sequence code and of count
DEPTH, 16, number of table entries (power of 2, >=2)
IDX_W, $clog2(DEPTH), width of index/address fields
LEN_W, IDX_W+1, width of seq_len

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
en  input  1  step enable; one step per cycle while high
dir  input  1  1 = step forward (idx+1), 0 = step backward (idx-1)
oneshot  input  1  1 = stop at end of sequence, 0 = wrap
start  input  1  restart pulse; reloads start index, clears done
seq_len  input  LEN_W  active sequence length; 0 or >DEPTH means DEPTH
wr_en  input  1  table write strobe
wr_addr  input  IDX_W  table write address
wr_data  input  WIDTH  table write data
count  output  WIDTH  current sequence code (registered)
idx  output  IDX_W  current table index (registered)
tc  output  1  combinational: idx at end for current dir (L-1 fwd, 0 bwd)
done  output  1  one-shot finished (sticky until start/reset)
par_err  output  1  sticky parity error (see Optional Feature)

Behaviour:
Reset and storage:
- Clock is clk; reset is asynchronous, active-low.
- reset low forces, immediately: idx=0, count=0, done=0, par_err=0.
- Reset also initialises table[i]=i (truncated to WIDTH), so count=table[0] after reset.
- Table: DEPTH x WIDTH registers, written synchronously when wr_en=1; a write takes effect the next cycle.

Effective length and end index:
- L = seq_len if 1..DEPTH, else DEPTH.
- End index E = L-1 when dir=1, 0 when dir=0.

Next-index priority per cycle (highest first):
1. start=1: idx <= (dir ? 0 : L-1); done <= 0. Applies even when en=0.
2. en=1 and done=0:
   - dir=1: idx == L-1 or idx >= L → next = 0 (wrap); otherwise idx+1.
   - dir=0: idx == 0 → next = L-1 (wrap); idx >= L → next = L-1; otherwise idx-1.
   - oneshot=1 and idx == E (idx in range): idx holds and done <= 1; no wrap.
3. Otherwise idx holds.

Count update:
- count <= table[next_idx] every cycle, so count always matches idx one cycle after it updates. Latency from en to new count is 1 cycle.
- Write/read collision: if wr_en=1 and wr_addr == next_idx in the same cycle, count <= wr_data (write forwarded).
- A write to the current idx without a step updates count next cycle through the same path.

Flags and boundary cases:
- done=1 blocks stepping until start or reset. Clearing oneshot while done=1 does not clear done.
- tc is combinational from idx, dir and L. L=1: tc is always 1 and idx stays 0.
- Changing dir mid-sequence takes effect on the next step; there is no skipped entry.
- seq_len changing below idx: the next step follows the idx>=L rules above.
- reset asserted mid-sequence aborts immediately and restores the identity table.

Optional Feature:
SEQCNT_PARITY_EN
- Defined: each table entry stores an extra even-parity bit computed from wr_data at write time (reset entries get correct parity). On every count load, stored parity is checked against the loaded code. A mismatch sets par_err (sticky until reset). Forwarded writes are not checked.
- Not defined: no parity storage; par_err tied to 0.

Test Plan:
- Reset then release, en=1, dir=1, oneshot=0, seq_len=0: count goes 0x00,0x01,…,0x0F,0x00; tc=1 exactly when idx=15.
- Write table[0..10] = 02,01,04,08,00,10,11,20,40,41,80; seq_len=11; start; en=1: count follows that order, then wraps 0x80→0x02.
- Same table, dir=0, start: count = 0x80 first, then 41,40,…,02; then wraps 0x02→0x80.
- oneshot=1, seq_len=4, dir=1, start, en held: count 02,01,04,08, then holds 0x08; done=1 from the 4th step onward. Pulse start: idx=0, count=0x02, done=0.
- Step to idx=2 while wr_en=1, wr_addr=2, wr_data=0xAA in the same cycle: count=0xAA next cycle.
- Assert reset at idx=6 mid-run: count=0x00 and idx=0 immediately; after release, count steps 0x00,0x01 (identity table restored).
- (SEQCNT_PARITY_EN) Force a table bit flip via bench backdoor at idx 3 and step onto it: par_err=1 the next cycle and stays 1.
